// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, multi-cycle data memory access
// with a stall handshake, and the MEM/WB pipeline register.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   RW, MtoR, MR, MW      control bits from EX/MEM
//   Branch, bne, zero     branch controls and ALU zero flag
//   aluANS                ALU result / byte address
//   rd2                   store data
//   b_tgt                 branch target
//   WN                    destination register number
//   pc_src, pc_tgt        branch-taken select and target to IF
//   mem_stall             freezes upstream stages while high
//   misalign_err          sticky misaligned-access flag
//   RW_out, MtoR_out      MEM/WB control bits
//   rdata_out, aluANS_out MEM/WB load data and ALU result
//   WN_out                MEM/WB destination register

module mem_stage #(
   parameter int MEM_WORDS  = 64,
   parameter int ACCESS_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RW,
   input  logic        MtoR,
   input  logic        MR,
   input  logic        MW,
   input  logic        Branch,
   input  logic        bne,
   input  logic        zero,
   input  logic [31:0] aluANS,
   input  logic [31:0] rd2,
   input  logic [31:0] b_tgt,
   input  logic [4:0]  WN,
   output logic        pc_src,
   output logic [31:0] pc_tgt,
   output logic        mem_stall,
   output logic        misalign_err,
   output logic        RW_out,
   output logic        MtoR_out,
   output logic [31:0] rdata_out,
   output logic [31:0] aluANS_out,
   output logic [4:0]  WN_out
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
   localparam logic [CW-1:0] LAST = CW'(ACCESS_LAT - 1);

   logic [31:0]   mem [MEM_WORDS];
   logic [CW-1:0] cnt;
   logic [AW-1:0] waddr;
   logic          acc;
   logic          aligned;
   logic          req;
   logic          mis;
   logic          ld;
   logic          wr_en;
   logic [31:0]   rd_word;
   logic          unused_hi;

   // Branch resolution is purely combinational and ignores stalls.
   assign pc_src = (Branch & zero) | (bne & ~zero);
   assign pc_tgt = b_tgt;

   // Upper address bits are dropped: the memory wraps.
   assign waddr     = aluANS[AW+1:2];
   assign unused_hi = ^aluANS[31:AW+2];

   assign acc     = MR | MW;
   assign aligned = (aluANS[1:0] == 2'b00);
   assign req     = acc & aligned;
   assign mis     = acc & ~aligned;

   // MR together with MW is treated as a write, so no load data.
   assign ld = req & MR & ~MW;

   // cnt == 0 is IDLE, cnt > 0 is WAIT; the last count is the
   // commit cycle, where the stall drops.
   assign mem_stall = req & (cnt != LAST);

   assign wr_en   = req & MW & ~mem_stall & ~reset;
   assign rd_word = mem[waddr];

   // Storage has no reset so contents survive it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[waddr] <= rd2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt          <= '0;
         misalign_err <= 1'b0;
         RW_out       <= 1'b0;
         MtoR_out     <= 1'b0;
         rdata_out    <= '0;
         aluANS_out   <= '0;
         WN_out       <= '0;
      end else begin
         if (mis) begin
            misalign_err <= 1'b1;
         end
         if (mem_stall) begin
            cnt <= cnt + CW'(1);
         end else begin
            cnt        <= '0;
            RW_out     <= RW;
            MtoR_out   <= MtoR;
            aluANS_out <= aluANS;
            WN_out     <= WN;
            rdata_out  <= ld ? rd_word : 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: three instances (ACCESS_LAT 1, 2, 4)
// checked against a behavioural model with directed and random ops.

module tb_mem_stage;

   localparam int ND = 3;
   localparam int MW_N = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset  [ND];
   logic        rw     [ND];
   logic        mtor   [ND];
   logic        mr     [ND];
   logic        mw     [ND];
   logic        br     [ND];
   logic        bn     [ND];
   logic        zr     [ND];
   logic [31:0] alu    [ND];
   logic [31:0] wd     [ND];
   logic [31:0] tgt    [ND];
   logic [4:0]  wn     [ND];
   logic        pc_src [ND];
   logic [31:0] pc_tgt [ND];
   logic        stall  [ND];
   logic        mis    [ND];
   logic        rw_o   [ND];
   logic        mtor_o [ND];
   logic [31:0] rd_o   [ND];
   logic [31:0] alu_o  [ND];
   logic [4:0]  wn_o   [ND];

   for (genvar g = 0; g < ND; g++) begin : g_dut
      mem_stage #(
         .MEM_WORDS (MW_N),
         .ACCESS_LAT((g == 0) ? 1 : ((g == 1) ? 2 : 4))
      ) dut (
         .clk         (clk),
         .reset       (reset[g]),
         .RW          (rw[g]),
         .MtoR        (mtor[g]),
         .MR          (mr[g]),
         .MW          (mw[g]),
         .Branch      (br[g]),
         .bne         (bn[g]),
         .zero        (zr[g]),
         .aluANS      (alu[g]),
         .rd2         (wd[g]),
         .b_tgt       (tgt[g]),
         .WN          (wn[g]),
         .pc_src      (pc_src[g]),
         .pc_tgt      (pc_tgt[g]),
         .mem_stall   (stall[g]),
         .misalign_err(mis[g]),
         .RW_out      (rw_o[g]),
         .MtoR_out    (mtor_o[g]),
         .rdata_out   (rd_o[g]),
         .aluANS_out  (alu_o[g]),
         .WN_out      (wn_o[g])
      );
   end

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [31:0] mdl     [ND][MW_N];
   logic        mflag   [ND];
   logic [31:0] prev_rd [ND];
   logic [31:0] prev_al [ND];

   function automatic int lat(int d);
      return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(int d);
      rw[d] = 0; mtor[d] = 0; mr[d] = 0; mw[d] = 0;
      br[d] = 0; bn[d] = 0; zr[d] = 0;
      alu[d] = 0; wd[d] = 0; tgt[d] = 0; wn[d] = 0;
   endtask

   task automatic do_reset(int d);
      idle(d);
      reset[d] = 1;
      @(posedge clk); #1;
      reset[d] = 0;
      mflag[d] = 0;
      prev_rd[d] = 0;
      prev_al[d] = 0;
      chk("rst_rw", 32'(rw_o[d]), 0);
      chk("rst_mtor", 32'(mtor_o[d]), 0);
      chk("rst_rdata", rd_o[d], 0);
      chk("rst_alu", alu_o[d], 0);
      chk("rst_wn", 32'(wn_o[d]), 0);
      chk("rst_mis", 32'(mis[d]), 0);
      @(negedge clk);
      chk("rst_stall", 32'(stall[d]), 0);
      @(posedge clk); #1;
   endtask

   // One MEM-stage transaction, held until the stage stops stalling.
   task automatic op(int d, bit r, bit w, bit rwi, bit mti,
                     bit b, bit n, bit z, logic [31:0] a,
                     logic [31:0] data, logic [31:0] t,
                     logic [4:0] wni);
      int st = 0;
      bit done = 0;
      bit rq, ms, ld;
      int idx;
      logic [31:0] exp_rd;
      rw[d] = rwi; mtor[d] = mti; mr[d] = r; mw[d] = w;
      br[d] = b; bn[d] = n; zr[d] = z;
      alu[d] = a; wd[d] = data; tgt[d] = t; wn[d] = wni;
      rq  = (r || w) && (a[1:0] == 2'b00);
      ms  = (r || w) && (a[1:0] != 2'b00);
      ld  = rq && r && !w;
      idx = int'((a >> 2) % MW_N);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk("pc_src", 32'(pc_src[d]),
                32'((b && z) || (n && !z)));
            chk("pc_tgt", pc_tgt[d], t);
         end
         if (!stall[d]) begin
            done = 1;
            break;
         end
         st++;
         chk("hold_rdata", rd_o[d], prev_rd[d]);
         chk("hold_alu", alu_o[d], prev_al[d]);
         @(posedge clk); #1;
      end
      if (!done) chk("stall_timeout", 0, 1);
      @(posedge clk); #1;
      exp_rd = ld ? mdl[d][idx] : 32'h0;
      if (rq && w) mdl[d][idx] = data;
      if (ms) mflag[d] = 1;
      chk("stall_len", 32'(st), rq ? 32'(lat(d) - 1) : 0);
      chk("rdata", rd_o[d], exp_rd);
      chk("alu_out", alu_o[d], a);
      chk("wn_out", 32'(wn_o[d]), 32'(wni));
      chk("rw_out", 32'(rw_o[d]), 32'(rwi));
      chk("mtor_out", 32'(mtor_o[d]), 32'(mti));
      chk("misalign", 32'(mis[d]), 32'(mflag[d]));
      prev_rd[d] = exp_rd;
      prev_al[d] = a;
   endtask

   task automatic store(int d, logic [31:0] a, logic [31:0] v);
      op(d, 0, 1, 0, 0, 0, 0, 0, a, v, 0, 0);
   endtask

   task automatic load(int d, logic [31:0] a, logic [4:0] w);
      op(d, 1, 0, 1, 1, 0, 0, 0, a, 0, 0, w);
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         idle(d);
         reset[d] = 1;
         mflag[d] = 0;
      end
      @(posedge clk); #1;

      for (int d = 0; d < ND; d++) begin
         do_reset(d);
         for (int i = 0; i < MW_N; i++)
            store(d, 32'(i * 4), $urandom);

         if (d == 1) begin
            store(d, 32'h10, 32'hDEADBEEF);
            op(d, 1, 0, 1, 1, 0, 0, 0, 32'h10, 0, 0, 5'd8);
            chk("req38_data", rd_o[d], 32'hDEADBEEF);
            op(d, 0, 0, 0, 0, 1, 0, 1, 0, 0, 32'h40, 0);
            op(d, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h40, 0);
            op(d, 1, 0, 1, 1, 0, 0, 0, 32'h13, 0, 0, 5'd3);
            chk("req40_flag", 32'(mis[d]), 1);
            op(d, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0);
            chk("req40_sticky", 32'(mis[d]), 1);
         end

         if (d == 0) begin
            store(d, 32'h0, 32'hCAFEF00D);
            load(d, 32'h0, 5'd2);
            chk("req42_data", rd_o[d], 32'hCAFEF00D);
            op(d, 1, 1, 0, 0, 0, 0, 0, 32'h44, 32'h1234, 0, 1);
            load(d, 32'h4, 5'd1);
         end

         if (d == 2) begin
            store(d, 32'h20, 32'h11111111);
            alu[d] = 32'h20; wd[d] = 32'h0BADBAD0;
            mw[d] = 1; mr[d] = 0;
            @(negedge clk);
            chk("abort_st1", 32'(stall[d]), 1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("abort_st2", 32'(stall[d]), 1);
            reset[d] = 1;
            @(posedge clk); #1;
            reset[d] = 0;
            idle(d);
            mflag[d] = 0;
            prev_rd[d] = 0;
            prev_al[d] = 0;
            chk("abort_rdata", rd_o[d], 0);
            chk("abort_alu", alu_o[d], 0);
            chk("abort_rw", 32'(rw_o[d]), 0);
            load(d, 32'h20, 5'd9);
            chk("abort_mem", rd_o[d], 32'h11111111);
         end

         for (int i = 0; i < 40; i++) begin
            int kind;
            logic [31:0] a;
            bit r, w;
            kind = $urandom_range(0, 5);
            r = (kind == 1) || (kind == 2) || (kind == 5);
            w = (kind == 3) || (kind == 4) || (kind == 5);
            a = $urandom & 32'hFFFF_FF7C;
            if ($urandom_range(0, 7) == 0)
               a[1:0] = 2'($urandom_range(1, 3));
            op(d, r, w, 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), a, $urandom, $urandom,
               5'($urandom));
         end

         do_reset(d);
         idle(d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
